// File: rtl/jam_pkg.sv
// Shared sizes and state encoding for the JAM sequencer and its cost store.
package jam_pkg;

    localparam int N_JOB   = 8;
    localparam int COST_W  = 7;
    localparam int MIN_W   = 10;
    localparam int MC_W    = 4;
    localparam int N_ENTRY = N_JOB * N_JOB;
    localparam int ADDR_W  = $clog2(N_ENTRY);

    typedef enum logic [1:0] {
        LOAD,
        KICK,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/jam_cost_regfile.sv
// 64-entry cost matrix: one synchronous write port, one combinational read port.
module jam_cost_regfile
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [COST_W-1:0] rdata
);

    // Contents are deliberately not reset; a fresh load always precedes use.
    logic [COST_W-1:0] mem [N_ENTRY];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jam_sched.sv
// Sequencer around the JAM search engine: loads the cost matrix, runs the engine
// under a watchdog, and hands the captured result back over a valid/ready port.
module jam_sched
    import jam_pkg::*;
#(
    parameter int TIMEOUT = 600000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COST_W-1:0] in_cost,
    output logic              jam_rst,
    input  logic [2:0]        jam_w,
    input  logic [2:0]        jam_j,
    output logic [COST_W-1:0] jam_cost,
    input  logic              jam_valid,
    input  logic [MIN_W-1:0]  jam_mincost,
    input  logic [MC_W-1:0]   jam_matchcount,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [MIN_W-1:0]  res_mincost,
    output logic [MC_W-1:0]   res_matchcount,
    output logic              res_err,
    output logic              busy
);

    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [WD_W-1:0]   wd;
    logic              wr_en;

    // in_ready is high exactly in LOAD, so this is the accepted-entry strobe.
    assign wr_en = (state == LOAD) && in_valid;

    jam_cost_regfile u_regfile (
        .CLK   (CLK),
        .we    (wr_en),
        .waddr (cnt),
        .wdata (in_cost),
        .raddr ({jam_w, jam_j}),
        .rdata (jam_cost)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= LOAD;
            cnt            <= '0;
            wd             <= '0;
            in_ready       <= 1'b1;
            jam_rst        <= 1'b1;
            busy           <= 1'b0;
            res_valid      <= 1'b0;
            res_mincost    <= '0;
            res_matchcount <= '0;
            res_err        <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == ADDR_W'(N_ENTRY - 1)) begin
                            state    <= KICK;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                KICK: begin
                    state   <= RUN;
                    jam_rst <= 1'b0;
                end
                // A real result beats a watchdog expiry landing on the same cycle.
                RUN: begin
                    if (jam_valid) begin
                        state          <= DONE;
                        jam_rst        <= 1'b1;
                        res_valid      <= 1'b1;
                        res_mincost    <= jam_mincost;
                        res_matchcount <= jam_matchcount;
                        res_err        <= 1'b0;
                    end else if (wd == WD_LAST) begin
                        state          <= DONE;
                        jam_rst        <= 1'b1;
                        res_valid      <= 1'b1;
                        res_mincost    <= '1;
                        res_matchcount <= '0;
                        res_err        <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= LOAD;
                        wd        <= '0;
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_jam_sched.sv
// Directed bench for jam_sched with a scripted stand-in for the JAM engine.
module tb_jam_sched;

    logic       CLK = 1'b0;
    logic       RST;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_cost;
    logic       jam_rst;
    logic [2:0] jam_w;
    logic [2:0] jam_j;
    logic [6:0] jam_cost;
    logic       jam_valid;
    logic [9:0] jam_mincost;
    logic [3:0] jam_matchcount;
    logic       res_valid;
    logic       res_ready;
    logic [9:0] res_mincost;
    logic [3:0] res_matchcount;
    logic       res_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    bit stub_fire    = 1'b0;
    bit stub_force   = 1'b0;
    int stub_latency = 0;
    int run_cycles   = 0;

    logic [6:0] exp_cost [64];

    typedef struct {
        int         pattern;
        bit         gaps;
        bit         early;
        bit         fire;
        int         latency;
        int         drv_min;
        int         drv_mc;
        int         hold;
        logic [9:0] exp_min;
        logic [3:0] exp_mc;
        logic       exp_err;
        int         exp_len;
    } vec_t;

    vec_t vecs [6];

    jam_sched #(.TIMEOUT(1000)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_cost        (in_cost),
        .jam_rst        (jam_rst),
        .jam_w          (jam_w),
        .jam_j          (jam_j),
        .jam_cost       (jam_cost),
        .jam_valid      (jam_valid),
        .jam_mincost    (jam_mincost),
        .jam_matchcount (jam_matchcount),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_mincost    (res_mincost),
        .res_matchcount (res_matchcount),
        .res_err        (res_err),
        .busy           (busy)
    );

    always #5 CLK = ~CLK;

    // Engine stand-in: counts cycles out of reset and pulses Valid once at the scripted latency.
    initial begin
        jam_valid = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (jam_rst !== 1'b0) begin
                run_cycles = 0;
                jam_valid  = stub_force;
            end else begin
                run_cycles = run_cycles + 1;
                jam_valid  = stub_force | (stub_fire && (run_cycles == stub_latency));
            end
        end
    end

    function automatic logic [6:0] costOf(input int p, input int k);
        int w = k / 8;
        int j = k % 8;
        case (p)
            0:       return (j == w) ? 7'd0 : 7'd50;
            1:       return ((j == w) || (j == 7 - w)) ? 7'd1 : 7'd50;
            default: return 7'((k * 5 + 3) % 128);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " in_ready"}, 32'(in_ready), 1);
        checkOutput({tag, " jam_rst"}, 32'(jam_rst), 1);
        checkOutput({tag, " busy"}, 32'(busy), 0);
        checkOutput({tag, " res_valid"}, 32'(res_valid), 0);
        checkOutput({tag, " res_mincost"}, 32'(res_mincost), 0);
        checkOutput({tag, " res_matchcount"}, 32'(res_matchcount), 0);
        checkOutput({tag, " res_err"}, 32'(res_err), 0);
    endtask

    task automatic loadMatrix(input int pattern, input bit gaps, input int count);
        int notready = 0;
        for (int k = 0; k < count; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(posedge CLK);
                    #1;
                end
            end
            if (in_ready !== 1'b1) notready++;
            in_valid   = 1'b1;
            in_cost    = costOf(pattern, k);
            exp_cost[k] = costOf(pattern, k);
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("in_ready during load", notready, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        int run_len = 0;
        int bad_ready = 0;
        int stall = 0;
        int mism = 0;
        bit got = 1'b0;
        jam_mincost    = 10'(v.drv_min);
        jam_matchcount = 4'(v.drv_mc);
        stub_fire      = v.fire;
        stub_latency   = v.latency;
        res_ready      = v.early;
        loadMatrix(v.pattern, v.gaps, 64);
        checkOutput("kick in_ready", 32'(in_ready), 0);
        checkOutput("kick jam_rst", 32'(jam_rst), 1);
        checkOutput("kick busy", 32'(busy), 1);
        for (int c = 0; c < 1200 && !got; c++) begin
            @(posedge CLK);
            #1;
            if (in_ready !== 1'b0) bad_ready++;
            if (res_valid === 1'b1) got = 1'b1;
            else if (jam_rst === 1'b0) run_len++;
        end
        checkOutput("result arrived", 32'(got), 1);
        checkOutput("in_ready while busy", bad_ready, 0);
        checkOutput("run length", run_len, v.exp_len);
        checkOutput("res_mincost", 32'(res_mincost), 32'(v.exp_min));
        checkOutput("res_matchcount", 32'(res_matchcount), 32'(v.exp_mc));
        checkOutput("res_err", 32'(res_err), 32'(v.exp_err));
        checkOutput("done jam_rst", 32'(jam_rst), 1);
        if (!v.early) begin
            stub_force     = 1'b1;
            jam_mincost    = ~10'(v.drv_min);
            jam_matchcount = ~4'(v.drv_mc);
            repeat (v.hold) begin
                @(posedge CLK);
                #1;
                if (res_valid !== 1'b1 || res_mincost !== v.exp_min ||
                    res_matchcount !== v.exp_mc || res_err !== v.exp_err) stall++;
            end
            checkOutput("done hold stable", stall, 0);
            stub_force = 1'b0;
            res_ready  = 1'b1;
        end
        @(posedge CLK);
        #1;
        res_ready = 1'b0;
        checkOutput("release res_valid", 32'(res_valid), 0);
        checkOutput("release in_ready", 32'(in_ready), 1);
        // Readback sweep in LOAD with a stray Valid that must be ignored.
        stub_force = 1'b1;
        for (int a = 0; a < 64; a++) begin
            jam_w = 3'(a / 8);
            jam_j = 3'(a % 8);
            #1;
            if (jam_cost !== exp_cost[a]) mism++;
        end
        checkOutput("jam_cost readback", mism, 0);
        @(posedge CLK);
        #1;
        stub_force = 1'b0;
        checkOutput("load ignores jam_valid", 32'(busy), 0);
    endtask

    initial begin
        RST            = 1'b1;
        in_valid       = 1'b0;
        in_cost        = '0;
        res_ready      = 1'b0;
        jam_w          = '0;
        jam_j          = '0;
        jam_mincost    = '0;
        jam_matchcount = '0;

        vecs[0] = '{0, 1'b0, 1'b0, 1'b1, 40, 0, 1, 10, 10'd0, 4'd1, 1'b0, 40};
        vecs[1] = '{1, 1'b0, 1'b1, 1'b1, 60, 8, 2, 0, 10'd8, 4'd2, 1'b0, 60};
        vecs[2] = '{0, 1'b1, 1'b0, 1'b1, 40, 0, 1, 5, 10'd0, 4'd1, 1'b0, 40};
        vecs[3] = '{2, 1'b0, 1'b0, 1'b1, 75, 777, 5, 100, 10'd777, 4'd5, 1'b0, 75};
        vecs[4] = '{1, 1'b1, 1'b0, 1'b0, 0, 321, 7, 3, 10'd1023, 4'd0, 1'b1, 1000};
        vecs[5] = '{2, 1'b0, 1'b1, 1'b1, 1, 1023, 15, 0, 10'd1023, 4'd15, 1'b0, 1};

        repeat (3) @(posedge CLK);
        #1;
        checkReset("init");
        RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset part-way through a load; the next full load must start from entry 0.
        loadMatrix(2, 1'b0, 30);
        #3;
        RST = 1'b1;
        #1;
        checkReset("load rst");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        applyStimulus('{0, 1'b0, 1'b0, 1'b1, 30, 5, 3, 2, 10'd5, 4'd3, 1'b0, 30});

        // Reset in the middle of a run with the engine silent.
        stub_fire = 1'b0;
        loadMatrix(1, 1'b0, 64);
        repeat (10) @(posedge CLK);
        #1;
        checkOutput("mid run jam_rst", 32'(jam_rst), 0);
        #3;
        RST = 1'b1;
        #1;
        checkReset("run rst");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        applyStimulus('{1, 1'b0, 1'b0, 1'b1, 50, 8, 2, 4, 10'd8, 4'd2, 1'b0, 50});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
